// File: rtl/lsu_mem.sv
// lsu_mem: memory-access stage of the toy MIPS core.
// Decodes load/store sub-ops, runs a req/ack RAM access, registers writeback.
module lsu_mem #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [3:0]    ex_lsop,
  input  logic [AW-1:0] ex_addr,
  input  logic [31:0]   ex_rt,
  input  logic          ex_wreg,
  input  logic [4:0]    ex_wd,
  input  logic [31:0]   ex_wdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [3:0]    ram_sel,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  input  logic          ram_ack,
  output logic          wb_valid,
  output logic          wb_wreg,
  output logic [4:0]    wb_wd,
  output logic [31:0]   wb_wdata,
  output logic          addr_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_LWL = 4'd6;
  localparam logic [3:0] OP_LWR = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  typedef enum logic {IDLE, REQ} state_e;

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   rt_q, rt_d;
  logic [4:0]    wd_q, wd_d;
  logic          wreg_q, wreg_d;
  logic          wbv_q, wbv_d;
  logic          wbw_q, wbw_d;
  logic [4:0]    wbd_q, wbd_d;
  logic [31:0]   wbdat_q, wbdat_d;
  logic          err_q, err_d;

  logic          ex_mem, ex_mis, st_q;
  logic [1:0]    o;
  logic [4:0]    sh_o, sh_r, sh_h;
  logic [3:0]    sel;
  logic [31:0]   sdata, ldata, lmask, rmask;
  logic [7:0]    lb;
  logic [15:0]   lh;

  assign ex_mem = (ex_lsop >= OP_LB) && (ex_lsop <= OP_SWR);
  assign ex_mis = (((ex_lsop == OP_LH) || (ex_lsop == OP_LHU) ||
                    (ex_lsop == OP_SH)) && ex_addr[0]) ||
                  (((ex_lsop == OP_LW) || (ex_lsop == OP_SW)) &&
                   (ex_addr[1:0] != 2'b00));

  // Big-endian lanes: offset 0 is bits 31:24, so shifts use 3-o.
  assign st_q = (op_q >= OP_SB) && (op_q <= OP_SWR);
  assign o    = addr_q[1:0];
  assign sh_o = {o, 3'b000};
  assign sh_r = {~o, 3'b000};
  assign sh_h = {~o[1], 4'b0000};

  always_comb begin
    sel   = 4'b1111;
    sdata = 32'd0;
    unique case (op_q)
      OP_SB:  begin sel = 4'b1000 >> o; sdata = {4{rt_q[7:0]}}; end
      OP_SH:  begin sel = 4'b1100 >> o; sdata = {2{rt_q[15:0]}}; end
      OP_SW:  sdata = rt_q;
      OP_SWL: begin sel = 4'b1111 >> o; sdata = rt_q >> sh_o; end
      OP_SWR: begin sel = ~(4'b0111 >> o); sdata = rt_q << sh_r; end
      default: ;
    endcase
  end

  always_comb begin
    lb    = 8'(ram_rdata >> sh_r);
    lh    = 16'(ram_rdata >> sh_h);
    lmask = ~(32'hFFFF_FFFF << sh_o);
    rmask = 32'hFFFF_FFFF >> sh_r;
    ldata = ram_rdata;
    unique case (op_q)
      OP_LB:  ldata = {{24{lb[7]}}, lb};
      OP_LBU: ldata = {24'd0, lb};
      OP_LH:  ldata = {{16{lh[15]}}, lh};
      OP_LHU: ldata = {16'd0, lh};
      OP_LWL: ldata = (ram_rdata << sh_o) | (rt_q & lmask);
      OP_LWR: ldata = (ram_rdata >> sh_r) | (rt_q & ~rmask);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rt_d    = rt_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wbv_d   = 1'b0;
    wbw_d   = 1'b0;
    wbd_d   = wbd_q;
    wbdat_d = wbdat_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_mem) begin
            wbv_d   = 1'b1;
            wbw_d   = ex_wreg;
            wbd_d   = ex_wd;
            wbdat_d = ex_wdata;
          end else if (ex_mis) begin
            wbv_d = 1'b1;
            wbd_d = ex_wd;
            err_d = 1'b1;
          end else begin
            op_d    = ex_lsop;
            addr_d  = ex_addr;
            rt_d    = ex_rt;
            wd_d    = ex_wd;
            wreg_d  = ex_wreg;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (ram_ack) begin
          state_d = IDLE;
          wbv_d   = 1'b1;
          wbd_d   = wd_q;
          if (!st_q) begin
            wbw_d   = wreg_q;
            wbdat_d = ldata;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      addr_q  <= '0;
      rt_q    <= 32'd0;
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      wbv_q   <= 1'b0;
      wbw_q   <= 1'b0;
      wbd_q   <= 5'd0;
      wbdat_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rt_q    <= rt_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wbv_q   <= wbv_d;
      wbw_q   <= wbw_d;
      wbd_q   <= wbd_d;
      wbdat_q <= wbdat_d;
      err_q   <= err_d;
    end
  end

  assign ex_ready  = (state_q == IDLE);
  assign ram_ce    = (state_q == REQ);
  assign ram_we    = ram_ce & st_q;
  assign ram_sel   = ram_ce ? sel : 4'b0000;
  assign ram_addr  = ram_ce ? {addr_q[AW-1:2], 2'b00} : '0;
  assign ram_wdata = ram_ce ? sdata : 32'd0;
  assign wb_valid  = wbv_q;
  assign wb_wreg   = wbw_q;
  assign wb_wd     = wbd_q;
  assign wb_wdata  = wbdat_q;
  assign addr_err  = err_q;

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed bench for lsu_mem with a RAM responder
// and a writeback scoreboard.
module tb_lsu_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_lsop;
  logic [31:0] ex_addr;
  logic [31:0] ex_rt;
  logic        ex_wreg;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack;
  logic        wb_valid, wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        addr_err;

  lsu_mem #(.AW(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_lsop(ex_lsop), .ex_addr(ex_addr), .ex_rt(ex_rt),
    .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_wd(wb_wd),
    .wb_wdata(wb_wdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        chk;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  logic        hold_ack = 1'b0;
  int          wait_cnt = 0;
  int          ce_cnt = 0;
  logic [31:0] mem_word = 32'd0;
  logic [3:0]  last_sel;
  logic [31:0] last_wdata, last_addr;
  logic        last_we;

  assign ram_ack   = ram_ce && !hold_ack && (wait_cnt >= ack_delay);
  assign ram_rdata = ram_ack ? mem_word : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    wait_cnt <= (ram_ce && !ram_ack) ? wait_cnt + 1 : 0;
    if (ram_ce) ce_cnt <= ce_cnt + 1;
  end

  always @(negedge clk)
    if (ram_ce && ram_ack) begin
      last_sel   = ram_sel;
      last_wdata = ram_wdata;
      last_addr  = ram_addr;
      last_we    = ram_we;
    end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic wreg, input logic [4:0] wd,
                              input logic [31:0] wdata,
                              input logic c, input logic err);
    exp_t e;
    e.wreg = wreg; e.wd = wd; e.wdata = wdata; e.chk = c; e.err = err;
    return e;
  endfunction

  // Scoreboard: every wb pulse must match the oldest expectation.
  always @(negedge clk)
    if (wb_valid) begin
      exp_t e;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL wb_extra got=pulse exp=none");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
        chk("addr_err", 32'(addr_err), 32'(e.err));
        if (e.wreg) chk("wb_wd", 32'(wb_wd), 32'(e.wd));
        if (e.chk) chk("wb_wdata", wb_wdata, e.wdata);
      end
    end

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] wdata, input logic [4:0] wd,
                        input logic wreg, input exp_t e,
                        input int exp_lat);
    int lat;
    int w;
    sb.push_back(e);
    ex_valid = 1'b1; ex_lsop = op; ex_addr = addr; ex_rt = rt;
    ex_wdata = wdata; ex_wd = wd; ex_wreg = wreg;
    w = 0;
    while (!ex_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ex_ready) chk({tag, "_accept"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 ex_valid = 1'b0; ex_lsop = 4'd0;
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      #1 lat++;
      if (sb.size() == 0) break;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int ce0;
    rst = 1'b1; ex_valid = 1'b0; ex_lsop = 4'd0; ex_addr = 32'd0;
    ex_rt = 32'd0; ex_wreg = 1'b0; ex_wd = 5'd0; ex_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_ce", 32'(ram_ce), 32'd0);
    chk("rst_sel", 32'(ram_sel), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);

    mem_word = 32'h4455_6677;
    run_op("lb", 4'd1, 32'h1, 32'h0, 32'h0, 5'd3, 1'b1,
           mk(1'b1, 5'd3, 32'h0000_0055, 1'b1, 1'b0), 2);
    chk("lb_addr", last_addr, 32'h0);
    chk("lb_sel", 32'(last_sel), 32'hF);
    chk("lb_we", 32'(last_we), 32'd0);
    run_op("lbu", 4'd2, 32'h3, 32'h0, 32'h0, 5'd4, 1'b1,
           mk(1'b1, 5'd4, 32'h0000_0077, 1'b1, 1'b0), 2);
    mem_word = 32'hAABB_8899;
    run_op("lh", 4'd3, 32'h2, 32'h0, 32'h0, 5'd5, 1'b1,
           mk(1'b1, 5'd5, 32'hFFFF_8899, 1'b1, 1'b0), 2);
    run_op("lhu", 4'd4, 32'h2, 32'h0, 32'h0, 5'd6, 1'b1,
           mk(1'b1, 5'd6, 32'h0000_8899, 1'b1, 1'b0), 2);
    run_op("lb_neg", 4'd1, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1,
           mk(1'b1, 5'd7, 32'hFFFF_FFAA, 1'b1, 1'b0), 2);

    run_op("sb", 4'd8, 32'h6, 32'h1122_3344, 32'h0, 5'd1, 1'b1,
           mk(1'b0, 5'd1, 32'h0, 1'b0, 1'b0), 2);
    chk("sb_sel", 32'(last_sel), 32'b0010);
    chk("sb_data", last_wdata, 32'h4444_4444);
    chk("sb_addr", last_addr, 32'h4);
    chk("sb_we", 32'(last_we), 32'd1);
    run_op("sh", 4'd9, 32'h2, 32'h1122_3344, 32'h0, 5'd1, 1'b0,
           mk(1'b0, 5'd1, 32'h0, 1'b0, 1'b0), 2);
    chk("sh_sel", 32'(last_sel), 32'b0011);
    chk("sh_data", last_wdata, 32'h3344_3344);
    run_op("swl", 4'd11, 32'h1, 32'h1122_3344, 32'h0, 5'd1, 1'b0,
           mk(1'b0, 5'd1, 32'h0, 1'b0, 1'b0), 2);
    chk("swl_sel", 32'(last_sel), 32'b0111);
    chk("swl_data", last_wdata, 32'h0011_2233);
    run_op("swr", 4'd12, 32'h1, 32'h1122_3344, 32'h0, 5'd1, 1'b0,
           mk(1'b0, 5'd1, 32'h0, 1'b0, 1'b0), 2);
    chk("swr_sel", 32'(last_sel), 32'b1100);
    chk("swr_data", last_wdata, 32'h3344_0000);
    run_op("sw", 4'd10, 32'h8, 32'h1122_3344, 32'h0, 5'd1, 1'b0,
           mk(1'b0, 5'd1, 32'h0, 1'b0, 1'b0), 2);
    chk("sw_sel", 32'(last_sel), 32'hF);
    chk("sw_data", last_wdata, 32'h1122_3344);
    chk("sw_addr", last_addr, 32'h8);

    mem_word = 32'h4455_6677;
    run_op("lwl", 4'd6, 32'h1, 32'hAABB_CCDD, 32'h0, 5'd8, 1'b1,
           mk(1'b1, 5'd8, 32'h5566_77DD, 1'b1, 1'b0), 2);
    run_op("lwr", 4'd7, 32'h2, 32'hAABB_CCDD, 32'h0, 5'd9, 1'b1,
           mk(1'b1, 5'd9, 32'hAA44_5566, 1'b1, 1'b0), 2);

    ack_delay = 3;
    mem_word = 32'h1234_5678;
    sb.push_back(mk(1'b1, 5'd10, 32'h1234_5678, 1'b1, 1'b0));
    ex_valid = 1'b1; ex_lsop = 4'd5; ex_addr = 32'h10;
    ex_wd = 5'd10; ex_wreg = 1'b1;
    @(posedge clk);
    #1 ex_valid = 1'b0; ex_lsop = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dly_ce", 32'(ram_ce), 32'd1);
      chk("dly_ready", 32'(ex_ready), 32'd0);
      chk("dly_addr", ram_addr, 32'h10);
      chk("dly_sel", 32'(ram_sel), 32'hF);
      chk("dly_wbv", 32'(wb_valid), 32'd0);
    end
    @(negedge clk);
    #1 chk("dly_wb", 32'(sb.size()), 32'd0);
    chk("dly_ready_after", 32'(ex_ready), 32'd1);
    ack_delay = 0;
    run_op("after_ack", 4'd0, 32'h0, 32'h0, 32'hCAFE_0001, 5'd11, 1'b1,
           mk(1'b1, 5'd11, 32'hCAFE_0001, 1'b1, 1'b0), 1);

    ce0 = ce_cnt;
    run_op("mis_lw", 4'd5, 32'h2, 32'h0, 32'h0, 5'd12, 1'b1,
           mk(1'b0, 5'd12, 32'h0, 1'b0, 1'b1), 1);
    run_op("mis_sh", 4'd9, 32'h1, 32'h0, 32'h0, 5'd12, 1'b0,
           mk(1'b0, 5'd12, 32'h0, 1'b0, 1'b1), 1);
    repeat (2) @(negedge clk);
    chk("mis_no_ce", 32'(ce_cnt - ce0), 32'd0);
    run_op("op13", 4'd13, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd13, 1'b1,
           mk(1'b1, 5'd13, 32'h0BAD_F00D, 1'b1, 1'b0), 1);

    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(1'b1, 5'(20 + i), 32'h100 + 32'(i), 1'b1, 1'b0));
      ex_valid = 1'b1; ex_lsop = 4'd0; ex_wreg = 1'b1;
      ex_wd = 5'(20 + i); ex_wdata = 32'h100 + 32'(i);
      @(negedge clk);
      chk("b2b_wbv", 32'(wb_valid), 32'd1);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    #1 chk("b2b_idle", 32'(wb_valid), 32'd0);
    chk("b2b_sb", 32'(sb.size()), 32'd0);

    hold_ack = 1'b1;
    ex_valid = 1'b1; ex_lsop = 4'd5; ex_addr = 32'h20;
    ex_wd = 5'd14; ex_wreg = 1'b1;
    @(posedge clk);
    #1 ex_valid = 1'b0; ex_lsop = 4'd0;
    repeat (2) @(negedge clk);
    chk("rq_ce", 32'(ram_ce), 32'd1);
    chk("rq_ready", 32'(ex_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rq_rst_ce", 32'(ram_ce), 32'd0);
    chk("rq_rst_ready", 32'(ex_ready), 32'd1);
    chk("rq_rst_wbv", 32'(wb_valid), 32'd0);
    hold_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rq_no_ce", 32'(ram_ce), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem.md
# lsu_mem

Memory-access pipeline stage of the toy MIPS core. It sits between the EX/MEM latch and the writeback/regfile write port, and drives the four-bank byte-lane data RAM. The stage decodes load/store sub-ops (byte, half, word, unaligned left/right) into a RAM word address, byte-select and lane-shifted write data. It sequences each access with a req/ack handshake, stalling upstream while busy. On loads it extracts, extends or merges the returned word, then registers the result toward writeback.

## Interface
- `AW`, 32: width of `ex_addr` / `ram_addr`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  upstream presents an instruction.
- `ex_ready`  out  1  stage accepts when `ex_valid & ex_ready`.
- `ex_lsop`  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR, others treated as 0.
- `ex_addr`  in  AW  effective byte address.
- `ex_rt`  in  32  rt value: store data, and merge source for LWL/LWR.
- `ex_wreg`  in  1  instruction writes a register.
- `ex_wd`  in  5  destination register.
- `ex_wdata`  in  32  ALU result, used when op = none.
- `ram_ce`  out  1  access request.
- `ram_we`  out  1  1 store, 0 load.
- `ram_sel`  out  4  byte enables; bit3 = bits 31:24 = bank3.
- `ram_addr`  out  AW  word-aligned address {addr[AW-1:2],2'b00}.
- `ram_wdata`  out  32  lane-positioned store data.
- `ram_rdata`  in  32  load data, valid when `ram_ack`.
- `ram_ack`  in  1  access complete this cycle; may be high in the first request cycle.
- `wb_valid`  out  1  wb_* hold a retired instruction this cycle.
- `wb_wreg`  out  1  register write enable.
- `wb_wd`  out  5  destination register.
- `wb_wdata`  out  32  write value.
- `addr_err`  out  1  one-cycle pulse: misaligned access dropped.

## Operation
- Big-endian lanes: byte offset o = addr[1:0]; o=0 selects bits 31:24, o=3 selects bits 7:0.
- FSM states IDLE, REQ. `ex_ready` = (state==IDLE). Reset → IDLE.
- IDLE, accepted op = none: next edge wb_valid=1, wb_wreg/wd/wdata = ex_*.
- IDLE, accepted memory op, aligned: latch op/addr/rt/wd/wreg, go to REQ. wb_valid=0 next cycle.
- Misaligned: LH/LHU/SH with o odd, or LW/SW with o≠0. Stay IDLE, no RAM access. Next edge: addr_err=1, wb_valid=1, wb_wreg=0.
- REQ: ram_ce=1, and ram_we/sel/addr/wdata stay stable until ack. On `ram_ack`: go to IDLE; next edge wb_valid=1 with load result, or wb_wreg=0 for stores.
- Store sel/data:
  - SB: sel one-hot by o (o=0→1000), data {4{rt[7:0]}}.
  - SH: o=0→1100, o=2→0011, data {2{rt[15:0]}}.
  - SW: 1111, data rt.
  - SWL o=0..3: sel 1111/0111/0011/0001, data rt>>(8·o).
  - SWR o=0..3: sel 1000/1100/1110/1111, data rt<<(8·(3−o)).
- Load sel: 1111 for all loads. Extraction from word m:
  - LB/LBU: byte at lane o, sign-/zero-extended.
  - LH/LHU: half at o, sign-/zero-extended.
  - LW: m.
  - LWL: {m[31−8o:0], rt[8o−1:0]}, giving m when o=0.
  - LWR: {rt[31:8(o+1)], m[31:8(3−o)]}, giving m when o=3.
- Outputs when not in REQ: ram_ce=0, ram_we=0, ram_sel=0.

## Timing
- Reset values: all outputs 0 except ex_ready=1; wb_* 0; addr_err 0.
- Non-memory op: 1 cycle to wb. Memory op with ack in first REQ cycle: wb at 2nd edge after acceptance. Each wait cycle adds 1.
- No ack: stage stays in REQ indefinitely and ex_ready stays 0.
- `rst` in REQ: next edge IDLE, ram_ce=0, in-flight op discarded with no wb_valid.
- wb_valid is a single-cycle pulse per retired instruction.
- ram_rdata is ignored unless ram_ack=1 in REQ with a load latched.

## Test plan
- RAM word 0x0 = 0x44556677, ack same cycle. LB @0x1 → wb_wdata 0x00000055, 2 cycles after accept. LBU @0x3 → 0x00000077. RAM word 0xAABB8899: LH @0x2 → 0xFFFF8899, LHU @0x2 → 0x00008899.
- rt=0x11223344: SB @0x6 → sel 0010, wdata 0x44444444. SH @0x2 → sel 0011. SWL @0x1 → sel 0111, wdata 0x00112233. SWR @0x1 → sel 1100, wdata 0x33440000.
- RAM 0x44556677, rt=0xAABBCCDD: LWL @0x1 → 0x556677DD. LWR @0x2 → 0xAA445566.
- ram_ack delayed 3 cycles on LW: ex_ready=0 and request signals stable for 4 cycles, wb_valid one pulse, next op accepted the cycle after ack.
- LW @0x2 → addr_err pulse, ram_ce never 1, wb_wreg=0. Back-to-back ALU ops → wb_valid every cycle.
- rst asserted in REQ while ack is withheld → ram_ce 0 next edge, no wb_valid, ex_ready=1.
